// File: rtl/mem_moc_responder.sv
// -----------------------------------------------------------------------------
// mem_moc_responder
//
// Memory-side responder for the control unit's MFA/MOC handshake. A request
// seen on MFA in IDLE is latched (ADDR, RW, SIZE, DATA_IN). After WAIT_CYCLES
// wait states, a byte, halfword or word access is made to a big-endian,
// byte-addressed memory, and MOC is raised. MOC is held until the control
// unit drops MFA.
//
// Parameters:
//   DEPTH       memory size in bytes (power of two, multiple of 4)
//   WAIT_CYCLES wait states between request acceptance and the access (0-15)
//
// Ports:
//   CLK       clock, rising edge
//   RESET     synchronous active-high reset (memory contents are kept)
//   MFA       memory function active, held by the CU until it sees MOC
//   RW        1 = read, 0 = write
//   SIZE      00 byte, 01 halfword, 10/11 word
//   ADDR      byte address (taken modulo DEPTH)
//   DATA_IN   write data (byte uses [7:0], halfword uses [15:0])
//   DATA_OUT  registered read data, zero-extended, held until the next read
//   MOC       memory operation complete
//   ABORT     (only with MEM_ALIGN_ABORT_EN) misaligned access flag, raised
//             together with MOC and cleared together with MOC
//
// Optional build macro: MEM_ALIGN_ABORT_EN. When it is defined, misaligned
// halfword or word accesses complete without any effect and flag ABORT.
// Otherwise they are force-aligned.
// -----------------------------------------------------------------------------
module mem_moc_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
`ifdef MEM_ALIGN_ABORT_EN
    output logic        ABORT,
`endif
    output logic        MOC
);

    localparam int AW   = $clog2(DEPTH);
    localparam int ROWS = DEPTH / 4;

`ifdef MEM_ALIGN_ABORT_EN
    localparam bit ALIGN_ABORT = 1'b1;
`else
    localparam bit ALIGN_ABORT = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_reg;
    logic [3:0]    cnt_reg;
    logic [AW-1:0] addr_reg;
    logic          rw_reg;
    logic [1:0]    size_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   data_out_reg;
    logic          moc_reg;

    // The upper address bits have no effect because addresses wrap modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDR[31:AW];

    logic          is_byte;
    logic          is_half;
    logic          misaligned;
    logic          misaligned_abort;
    logic [AW-1:0] eff_addr;
    logic [AW-3:0] row_idx;
    logic [1:0]    lane_off;
    logic [31:0]   rd_data;
    logic [3:0][7:0] lane_rdata;
    logic [3:0]      lane_we;
    logic [3:0][7:0] lane_wdata;
    logic          access_fire;
    logic          mem_write;

    always_comb begin
        is_byte  = (size_reg == 2'b00);
        is_half  = (size_reg == 2'b01);
        eff_addr = addr_reg;
        if (is_half)
            eff_addr[0] = 1'b0;
        else if (!is_byte)
            eff_addr[1:0] = 2'b00;
        misaligned = is_half ? addr_reg[0] : (!is_byte && (addr_reg[1:0] != 2'b00));
        misaligned_abort = ALIGN_ABORT && misaligned;

        // Lane 0 holds the lowest byte address of a row, so it is the MSB of a word.
        rd_data = 32'd0;
        if (is_byte)
            rd_data[7:0] = lane_rdata[lane_off];
        else if (is_half)
            rd_data[15:0] = {lane_rdata[{lane_off[1], 1'b0}], lane_rdata[{lane_off[1], 1'b1}]};
        else
            rd_data = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};
    end

    assign row_idx  = eff_addr[AW-1:2];
    assign lane_off = eff_addr[1:0];

    // A reset on the same edge as the access takes priority, so an aborted
    // write never reaches the memory.
    assign access_fire = (state_reg == ST_BUSY) && MFA && (cnt_reg == 4'd0) && !RESET;
    assign mem_write   = access_fire && !rw_reg && !misaligned_abort;

    // Memory is split into four byte lanes, so that one row holds one aligned word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] bank_mem [0:ROWS-1];

            assign lane_we[gi] = is_byte ? (lane_off == LANE) :
                                 is_half ? (lane_off[1] == LANE[1]) : 1'b1;
            assign lane_wdata[gi] = is_byte ? wdata_reg[7:0] :
                                    is_half ? (LANE[0] ? wdata_reg[7:0] : wdata_reg[15:8]) :
                                              wdata_reg[31-8*gi -: 8];

            always_ff @(posedge CLK) begin
                if (mem_write && lane_we[gi])
                    bank_mem[row_idx] <= lane_wdata[gi];
            end

            assign lane_rdata[gi] = bank_mem[row_idx];
        end
    endgenerate

`ifdef MEM_ALIGN_ABORT_EN
    logic abort_reg;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            rw_reg       <= 1'b0;
            size_reg     <= 2'b00;
            wdata_reg    <= 32'd0;
            data_out_reg <= 32'd0;
            moc_reg      <= 1'b0;
`ifdef MEM_ALIGN_ABORT_EN
            abort_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (MFA) begin
                        addr_reg  <= ADDR[AW-1:0];
                        rw_reg    <= RW;
                        size_reg  <= SIZE;
                        wdata_reg <= DATA_IN;
                        cnt_reg   <= 4'(WAIT_CYCLES);
                        state_reg <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!MFA) begin
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        moc_reg   <= 1'b1;
                        state_reg <= ST_DONE;
                        if (rw_reg && !misaligned_abort)
                            data_out_reg <= rd_data;
`ifdef MEM_ALIGN_ABORT_EN
                        abort_reg <= misaligned;
`endif
                    end
                end
                ST_DONE: begin
                    // Stay here while MFA is held, so a long MFA cannot start
                    // a second access.
                    if (!MFA) begin
                        moc_reg   <= 1'b0;
                        state_reg <= ST_IDLE;
`ifdef MEM_ALIGN_ABORT_EN
                        abort_reg <= 1'b0;
`endif
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign DATA_OUT = data_out_reg;
    assign MOC      = moc_reg;
`ifdef MEM_ALIGN_ABORT_EN
    assign ABORT    = abort_reg;
`endif

endmodule
